// File: rtl/replay_ctrl.sv
// replay_ctrl: retransmit buffer controller. New words are written into an
// external 8-entry RAM at their sequence number and forwarded downstream. ACKs
// retire entries. A NAK retires the entries up to and including the NAKed one,
// then re-sends every remaining entry from the RAM.
module replay_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    input  logic [15:0] tx_data,
    output logic        tx_ready,
    input  logic        ack_valid,
    input  logic [2:0]  ack_seq,
    input  logic        nak_valid,
    input  logic [2:0]  nak_seq,
    output logic [2:0]  ram_w_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    output logic [2:0]  ram_r_addr,
    output logic        ram_oe,
    input  logic [15:0] ram_dout,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [2:0]  out_seq,
    output logic        out_replay,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RPL_RD    = 2'd1,
        RPL_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ack_ptr_q, ack_ptr_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  rpl_left_q, rpl_left_d;
    logic        out_valid_q, out_valid_d;
    logic        out_replay_q, out_replay_d;
    logic [2:0]  out_seq_q, out_seq_d;
    logic [15:0] out_data_q, out_data_d;

    logic        wr_fire;
    logic [2:0]  ack_off, nak_off;
    logic [3:0]  ack_free, nak_free, freed, nak_left;

    // Acceptance: only in IDLE, with room, and never while a NAK is pending.
    assign tx_ready   = rst_n && (state_q == IDLE) && (count_q != 4'd8) && !nak_valid;
    assign wr_fire    = tx_valid && tx_ready;

    assign ram_we     = wr_fire;
    assign ram_w_addr = wr_ptr_q;
    assign ram_din    = tx_data;
    assign ram_r_addr = rd_ptr_q;
    assign ram_oe     = (state_q != IDLE);

    // Offsets from the oldest unacked entry; sequence arithmetic wraps mod 8.
    assign ack_off  = ack_seq - ack_ptr_q;
    assign nak_off  = nak_seq - ack_ptr_q;
    // A NAK overrides a simultaneous ACK; a NAK outside IDLE retires nothing.
    assign ack_free = (ack_valid && !nak_valid && ({1'b0, ack_off} < count_q))
                      ? ({1'b0, ack_off} + 4'd1) : 4'd0;
    assign nak_free = (nak_valid && (state_q == IDLE) && ({1'b0, nak_off} < count_q))
                      ? ({1'b0, nak_off} + 4'd1) : 4'd0;
    assign freed    = ack_free | nak_free;
    assign nak_left = count_q - nak_free;

    // Replayed words come straight from the RAM, which answers one cycle late.
    assign out_valid  = out_valid_q;
    assign out_replay = out_replay_q;
    assign out_seq    = out_seq_q;
    assign out_data   = out_replay_q ? ram_dout : out_data_q;

    assign count = count_q;
    assign full  = (count_q == 4'd8);
    assign empty = (count_q == 4'd0);

    // Next-state: pointer/count bookkeeping, replay sequencing and output staging.
    always_comb begin
        state_d      = state_q;
        ack_ptr_d    = ack_ptr_q + freed[2:0];
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + {3'b000, wr_fire} - freed;
        rpl_left_d   = rpl_left_q;
        out_valid_d  = 1'b0;
        out_replay_d = 1'b0;
        out_seq_d    = out_seq_q;
        out_data_d   = out_data_q;

        if (wr_fire) begin
            wr_ptr_d    = wr_ptr_q + 3'd1;
            out_valid_d = 1'b1;
            out_data_d  = tx_data;
            out_seq_d   = wr_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (nak_valid && (nak_left != 4'd0)) begin
                    state_d    = RPL_RD;
                    rd_ptr_d   = ack_ptr_q + nak_free[2:0];
                    rpl_left_d = nak_left;
                end
            end
            RPL_RD: begin
                // Replay runs to wr_ptr-1 even if ACKs shrink count meanwhile.
                rd_ptr_d     = rd_ptr_q + 3'd1;
                rpl_left_d   = rpl_left_q - 4'd1;
                out_valid_d  = 1'b1;
                out_replay_d = 1'b1;
                out_seq_d    = rd_ptr_q;
                if (rpl_left_q == 4'd1) begin
                    state_d = RPL_DRAIN;
                end
            end
            RPL_DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any replay immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ack_ptr_q    <= 3'd0;
            wr_ptr_q     <= 3'd0;
            rd_ptr_q     <= 3'd0;
            count_q      <= 4'd0;
            rpl_left_q   <= 4'd0;
            out_valid_q  <= 1'b0;
            out_replay_q <= 1'b0;
            out_seq_q    <= 3'd0;
            out_data_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            ack_ptr_q    <= ack_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rpl_left_q   <= rpl_left_d;
            out_valid_q  <= out_valid_d;
            out_replay_q <= out_replay_d;
            out_seq_q    <= out_seq_d;
            out_data_q   <= out_data_d;
        end
    end

endmodule

// File: doc/replay_ctrl.md
REPLAY_CTRL -- requirements
Module: replay_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
  clk  in 1  rising-edge clock
  rst_n  in 1  asynchronous, active-low reset
  tx_valid  in 1  new word offered
  tx_data  in 16  new word
  tx_ready  out 1  controller accepts tx_data this cycle
  ack_valid  in 1  ACK strobe
  ack_seq  in 3  ACK sequence number
  nak_valid  in 1  NAK strobe
  nak_seq  in 3  NAK sequence number
  ram_w_addr  out 3  RAM write address
  ram_din  out 16  RAM write data
  ram_we  out 1  RAM write enable
  ram_r_addr  out 3  RAM read address
  ram_oe  out 1  RAM output enable
  ram_dout  in 16  RAM read data; valid the cycle after ram_r_addr is sampled, only while ram_we=0 and ram_oe=1
  out_valid  out 1  word on out_data
  out_data  out 16  transmitted or replayed word
  out_seq  out 3  sequence number of out_data
  out_replay  out 1  out_data is a replay
  count  out 4  unacknowledged entries, 0..8
  full  out 1  count==8
  empty  out 1  count==0

Function
REQ-002 SHALL hold oldest-unacked pointer ack_ptr (3b), next-sequence pointer wr_ptr (3b), and count (4b); the sequence number equals the RAM address; pointers wrap 7->0.
REQ-003 SHALL implement the states IDLE, RPL_RD and RPL_DRAIN.
REQ-004 tx_ready SHALL be 1 only in IDLE with count<8 and no nak_valid this cycle.
REQ-005 On tx_valid&tx_ready: ram_we=1, ram_w_addr=wr_ptr, ram_din=tx_data (combinational, same cycle); wr_ptr+=1, count+=1 at the next edge.
REQ-006 An accepted word SHALL appear the next cycle with out_valid=1, out_data=word, out_seq=its sequence number, out_replay=0.
REQ-007 ACK: offset=(ack_seq-ack_ptr) mod 8; if offset<count, free offset+1 entries (ack_ptr+=offset+1, count-=offset+1); otherwise ignore (stale).
REQ-008 A write and an ACK in the same cycle SHALL both take effect: count_next = count + 1 - freed.
REQ-009 NAK in IDLE: apply REQ-007 freeing using nak_seq; if remaining count>0, enter RPL_RD with rd_ptr=new ack_ptr and rpl_left=remaining count; otherwise stay in IDLE.
REQ-010 nak_valid and ack_valid together: NAK wins and the ACK is ignored.
REQ-011 RPL_RD SHALL, each cycle: ram_r_addr=rd_ptr, ram_oe=1, ram_we=0, rd_ptr+=1, rpl_left-=1; it SHALL go to RPL_DRAIN when rpl_left reaches 1.
REQ-012 The cycle after each read issue: out_valid=1, out_data=ram_dout, out_seq=issued address, out_replay=1.
REQ-013 RPL_DRAIN SHALL last one cycle to present the final word, then return to IDLE.
REQ-014 ram_we SHALL be 0 throughout RPL_RD, RPL_DRAIN and the cycle after entry to IDLE from RPL_DRAIN is not restricted; ram_oe=1 in all replay states.
REQ-015 ACK during replay SHALL free entries per REQ-007; replay still completes to wr_ptr-1, because RAM contents are unchanged (no writes in replay).
REQ-016 NAK during replay SHALL be ignored.
REQ-017 full and empty SHALL be combinational from count; count SHALL never exceed 8 or drop below 0.

Reset
REQ-018 rst_n low SHALL immediately force: state=IDLE, pointers=0, count=0, full=0, empty=1, ram_we=0, ram_oe=0, out_valid=0, out_replay=0, out_data=0, out_seq=0, tx_ready=0.
REQ-019 tx_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-020 Reset asserted mid-replay SHALL abort the replay with no further out_valid.

Verification
REQ-021 Write 10,20,30 -> ram_we pulses at addresses 0,1,2; out_seq 0,1,2 with out_replay=0; count=3.
REQ-022 Write 8 words -> full=1, tx_ready=0; a 9th tx_valid causes no write.
REQ-023 With 5 outstanding (seq 0..4), ACK seq 1 -> count=3, ack_ptr=2; then ACK seq 1 again -> ignored.
REQ-024 With seq 0..4 outstanding, NAK seq 1 -> count=3; replay of data from addresses 2,3,4 with out_replay=1, one word per cycle starting 2 cycles after NAK; tx_ready=0 throughout.
REQ-025 Wrap: write 8, ACK 7, write 3 more -> addresses 0,1,2 reused; NAK 0 -> replays seq 1,2.
REQ-026 Reset pulse in RPL_RD -> outputs match REQ-018 with no further replay.
